// File: rtl/wbl_write_seq.sv
// Sweeps the WBL generator address range over a latched AES-128 key. For each address it
// waits for the generator to settle, captures its 16 words and streams them to the array write port.
module wbl_write_seq #(
  parameter int NUM_ADDR      = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_WORDS     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [127:0]  key_in,
  output logic [127:0]  gen_key,
  output logic [5:0]    gen_addr,
  input  logic [1023:0] gen_wbl,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [5:0]    wr_addr,
  output logic [3:0]    wr_word,
  output logic [63:0]   wr_data,
  output logic          busy,
  output logic          done
);
  localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [5:0]      ADDR_LAST   = 6'(NUM_ADDR - 1);
  localparam logic [3:0]      BEAT_LAST   = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [127:0]     r_key;
  logic [5:0]       r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_beat;
  logic [63:0]      r_buf [NUM_WORDS];
  logic             w_abort;
  logic             w_fire;

  // A beat coinciding with abort is not taken.
  assign w_abort = abort && (r_state != S_IDLE);
  assign w_fire  = (r_state == S_WRITE) && wr_ready && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    wr_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE:  if (r_cnt == SETTLE_LAST) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_WRITE;
      S_WRITE: begin
        wr_valid = 1'b1;
        if (w_fire && (r_beat == BEAT_LAST))
          w_next = (r_addr == ADDR_LAST) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_beat <= '0;
      for (int k = 0; k < NUM_WORDS; k++) r_buf[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key  <= key_in;
            r_addr <= '0;
            r_cnt  <= '0;
          end
        end
        S_SETTLE: r_cnt <= r_cnt + 1'b1;
        S_CAPTURE: begin
          // WBL1 sits in the top word of the packed generator bus.
          for (int k = 0; k < NUM_WORDS; k++) r_buf[k] <= gen_wbl[64*(15-k) +: 64];
          r_beat <= '0;
        end
        S_WRITE: begin
          if (w_fire) begin
            if (r_beat != BEAT_LAST) begin
              r_beat <= r_beat + 1'b1;
            end else if (r_addr != ADDR_LAST) begin
              r_addr <= r_addr + 1'b1;
              r_cnt  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gen_key  = r_key;
  assign gen_addr = r_addr;
  assign wr_addr  = r_addr;
  assign wr_word  = r_beat;
  assign wr_data  = r_buf[r_beat];

endmodule

// File: tb/tb_wbl_write_seq.sv
// Directed bench for wbl_write_seq: a behavioural generator model feeds gen_wbl, a monitor
// records handshakes, and one task per scenario checks beats, timing and control outputs.
module tb_wbl_write_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [127:0]  key_in = '0;
  logic [127:0]  gen_key;
  logic [5:0]    gen_addr;
  logic [1023:0] gen_wbl;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [5:0]    wr_addr;
  logic [3:0]    wr_word;
  logic [63:0]   wr_data;
  logic          busy, done;

  logic          start_s = 1'b0;
  logic          abort_s = 1'b0;
  logic [127:0]  key_s = '0;
  logic [127:0]  gen_key_s;
  logic [5:0]    gen_addr_s;
  logic [1023:0] gen_wbl_s;
  logic          wr_valid_s;
  logic          wr_ready_s = 1'b1;
  logic [5:0]    wr_addr_s;
  logic [3:0]    wr_word_s;
  logic [63:0]   wr_data_s;
  logic          busy_s, done_s;

  wbl_write_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
    .gen_key(gen_key), .gen_addr(gen_addr), .gen_wbl(gen_wbl),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_word(wr_word),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  wbl_write_seq #(.NUM_ADDR(3), .SETTLE_CYCLES(1), .NUM_WORDS(16)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .key_in(key_s),
    .gen_key(gen_key_s), .gen_addr(gen_addr_s), .gen_wbl(gen_wbl_s),
    .wr_valid(wr_valid_s), .wr_ready(wr_ready_s), .wr_addr(wr_addr_s), .wr_word(wr_word_s),
    .wr_data(wr_data_s), .busy(busy_s), .done(done_s)
  );

  // Stand-in for the combinational key generator: a fixed mix of key, address and word index.
  function automatic logic [63:0] ref_wbl(input logic [127:0] k, input int a, input int w);
    logic [63:0] lo;
    logic [63:0] m;
    lo = k[63:0];
    m  = 64'h9E3779B97F4A7C15 * 64'(a * 16 + w + 1);
    return (k[127:64] ^ m) + ((lo << w) | (lo >> (64 - w)));
  endfunction

  always_comb begin
    gen_wbl = '0;
    for (int k = 0; k < 16; k++) gen_wbl[64*(15-k) +: 64] = ref_wbl(gen_key, int'(gen_addr), k);
  end

  always_comb begin
    gen_wbl_s = '0;
    for (int k = 0; k < 16; k++) gen_wbl_s[64*(15-k) +: 64] = ref_wbl(gen_key_s, int'(gen_addr_s), k);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: ready high, 1: random with a 20-cycle stall at addr 32 word 0, 2: stall forever at addr 10
  int ready_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        if (wr_valid && wr_addr == 6'd32 && wr_word == 4'd0 && stall_cnt < 20) begin
          wr_ready = 1'b0;
          stall_cnt++;
        end else begin
          wr_ready = 1'($urandom_range(0, 1));
        end
      end
      2:       wr_ready = !(wr_valid && wr_addr == 6'd10);
      default: wr_ready = 1'b1;
    endcase
  end

  logic [5:0]  q_addr [$];
  logic [3:0]  q_word [$];
  logic [63:0] q_data [$];
  int          q_cyc  [$];
  int          done_cyc [$];
  int          stall_viol = 0;
  logic        p_hold = 1'b0;
  logic [5:0]  p_addr;
  logic [3:0]  p_word;
  logic [63:0] p_data;

  always @(negedge clk) begin
    if (p_hold && (wr_valid !== 1'b1 || wr_addr !== p_addr || wr_word !== p_word || wr_data !== p_data))
      stall_viol++;
    p_hold = rst_n && !abort && wr_valid && !wr_ready;
    p_addr = wr_addr;
    p_word = wr_word;
    p_data = wr_data;
    if (rst_n && !abort && wr_valid && wr_ready) begin
      q_addr.push_back(wr_addr);
      q_word.push_back(wr_word);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_mon();
    q_addr.delete(); q_word.delete(); q_data.delete(); q_cyc.delete(); done_cyc.delete();
    stall_viol = 0;
    stall_cnt = 0;
  endtask

  task automatic do_start(input logic [127:0] k, output int t0);
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = ~k;
    t0 = cyc;
  endtask

  task automatic wait_not_busy(input int bound, output bit to);
    to = 1'b1;
    for (int n = 0; n < bound; n++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gen_key !== 128'd0) begin failures++; $display("FAIL reset_gen_key got %h want 0", gen_key); end
    checks++; if (gen_addr !== 6'd0) begin failures++; $display("FAIL reset_gen_addr got %0d want 0", gen_addr); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    checks++; if (wr_data !== 64'd0) begin failures++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (busy_s !== 1'b0 || wr_valid_s !== 1'b0) begin failures++; $display("FAIL reset_small got %b%b want 00", busy_s, wr_valid_s); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_sweep();
    int t0, errs, bad, endc;
    bit to;
    clear_mon();
    ready_mode = 0;
    do_start(KEY_A, t0);
    checks++; if (gen_key !== KEY_A) begin failures++; $display("FAIL full_key_latch got %h want %h", gen_key, KEY_A); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_start got %b want 1", busy); end
    wait_not_busy(1400, to);
    endc = cyc - t0 + 1;
    checks++; if (to) begin failures++; $display("FAIL full_timeout got busy=%b want 0", busy); end
    checks++; if (q_addr.size() != 1024) begin failures++; $display("FAIL full_beat_count got %0d want 1024", q_addr.size()); end
    errs = 0; bad = -1;
    for (int i = 0; i < q_addr.size() && i < 1024; i++)
      if (q_addr[i] !== 6'(i / 16) || q_word[i] !== 4'(i % 16) || q_data[i] !== ref_wbl(KEY_A, i / 16, i % 16)) begin
        errs++; if (bad < 0) bad = i;
      end
    checks++; if (errs != 0) begin failures++; $display("FAIL full_beats got %0d bad beats (first %0d) want 0", errs, bad); end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL full_done_count got %0d want 1", done_cyc.size()); end
    checks++;
    if (done_cyc.size() == 0 || done_cyc[0] - t0 + 1 != 1217) begin
      failures++; $display("FAIL full_done_cycle got %0d want 1217", done_cyc.size() ? done_cyc[0] - t0 + 1 : -1);
    end
    checks++; if (endc != 1218) begin failures++; $display("FAIL full_busy_fall got cycle %0d want 1218", endc); end
    checks++; if (gen_key !== KEY_A || done !== 1'b0) begin failures++; $display("FAIL full_key_kept got %h done=%b want %h done=0", gen_key, done, KEY_A); end
  endtask

  task automatic test_start_ignored();
    int t0, errs;
    bit to;
    clear_mon();
    ready_mode = 0;
    do_start(KEY_A, t0);
    repeat (99) @(posedge clk);
    #1;
    start = 1'b1; key_in = KEY_B;
    @(posedge clk); #1;
    start = 1'b0;
    wait_not_busy(1400, to);
    checks++; if (to) begin failures++; $display("FAIL ignore_timeout got busy=%b want 0", busy); end
    errs = 0;
    for (int i = 0; i < q_addr.size() && i < 1024; i++)
      if (q_addr[i] !== 6'(i / 16) || q_word[i] !== 4'(i % 16) || q_data[i] !== ref_wbl(KEY_A, i / 16, i % 16)) errs++;
    checks++; if (errs != 0 || q_addr.size() != 1024) begin failures++; $display("FAIL ignore_beats got %0d beats %0d bad want 1024 0", q_addr.size(), errs); end
    checks++; if (gen_key !== KEY_A) begin failures++; $display("FAIL ignore_key got %h want %h", gen_key, KEY_A); end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 + 1 != 1217) begin
      failures++; $display("FAIL ignore_done got %0d pulses want 1 at 1217", done_cyc.size());
    end
  endtask

  task automatic test_back_to_back_stall();
    int t0, errs;
    bit to;
    clear_mon();
    ready_mode = 1;
    do_start(KEY_A, t0);
    wait_not_busy(6000, to);
    ready_mode = 0;
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got busy=%b want 0", busy); end
    errs = 0;
    for (int i = 0; i < q_addr.size() && i < 1024; i++)
      if (q_addr[i] !== 6'(i / 16) || q_word[i] !== 4'(i % 16) || q_data[i] !== ref_wbl(KEY_A, i / 16, i % 16)) errs++;
    checks++; if (errs != 0 || q_addr.size() != 1024) begin failures++; $display("FAIL bp_beats got %0d beats %0d bad want 1024 0", q_addr.size(), errs); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_viol); end
    checks++; if (stall_cnt != 20) begin failures++; $display("FAIL bp_long_stall got %0d want 20", stall_cnt); end
    checks++;
    if (done_cyc.size() != 1 || q_cyc.size() == 0 || done_cyc[0] != q_cyc[q_cyc.size()-1] + 1) begin
      failures++; $display("FAIL bp_done got %0d pulses want 1 right after last beat", done_cyc.size());
    end
  endtask

  task automatic test_abort();
    int t0;
    bit found;
    clear_mon();
    ready_mode = 0;
    do_start(KEY_A, t0);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (wr_valid && wr_addr == 6'd5 && wr_word == 4'd7) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_reach got addr %0d word %0d want 5 7", wr_addr, wr_word); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || wr_valid !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b valid=%b want 0 0", busy, wr_valid); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (q_addr.size() != 87) begin failures++; $display("FAIL abort_beats got %0d want 87", q_addr.size()); end
    checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL abort_no_done got %0d want 0", done_cyc.size()); end
    clear_mon();
    do_start(KEY_B, t0);
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (q_addr.size() < 16 || q_addr[0] !== 6'd0 || q_word[0] !== 4'd0 || q_data[0] !== ref_wbl(KEY_B, 0, 0) ||
        q_word[15] !== 4'd15 || q_data[15] !== ref_wbl(KEY_B, 0, 15)) begin
      failures++; $display("FAIL abort_restart got %0d beats want addr 0 words 0..15 first", q_addr.size());
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_second got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_midstall();
    int t0, errs;
    bit to, found;
    clear_mon();
    ready_mode = 2;
    do_start(KEY_A, t0);
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (wr_valid && wr_addr == 6'd10) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!found || q_addr.size() != 160 || wr_valid !== 1'b1) begin failures++; $display("FAIL rst_stall_reach got %0d beats valid=%b want 160 1", q_addr.size(), wr_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (gen_key !== 128'd0 || gen_addr !== 6'd0) begin failures++; $display("FAIL rst_mid_gen got %h %0d want 0 0", gen_key, gen_addr); end
    checks++; if (wr_valid !== 1'b0 || wr_addr !== 6'd0 || wr_word !== 4'd0) begin failures++; $display("FAIL rst_mid_wr got %b %0d %0d want 0 0 0", wr_valid, wr_addr, wr_word); end
    checks++; if (wr_data !== 64'd0) begin failures++; $display("FAIL rst_mid_data got %h want 0", wr_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got %b%b want 00", busy, done); end
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    clear_mon();
    do_start(KEY_B, t0);
    wait_not_busy(1400, to);
    errs = 0;
    for (int i = 0; i < q_addr.size() && i < 1024; i++)
      if (q_addr[i] !== 6'(i / 16) || q_word[i] !== 4'(i % 16) || q_data[i] !== ref_wbl(KEY_B, i / 16, i % 16)) errs++;
    checks++; if (to || errs != 0 || q_addr.size() != 1024) begin failures++; $display("FAIL rst_resweep got %0d beats %0d bad want 1024 0", q_addr.size(), errs); end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 + 1 != 1217) begin
      failures++; $display("FAIL rst_resweep_done got %0d pulses want 1 at 1217", done_cyc.size());
    end
  endtask

  task automatic test_small_config();
    int n, errs, special_errs, ndone, dcyc;
    start_s = 1'b1;
    key_s   = KEY_A;
    @(posedge clk); #1;
    start_s = 1'b0;
    key_s   = KEY_B;
    n = 0; errs = 0; special_errs = 0; ndone = 0; dcyc = -1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (wr_valid_s && wr_ready_s) begin
        if (wr_addr_s !== 6'(n / 16) || wr_word_s !== 4'(n % 16) || wr_data_s !== ref_wbl(KEY_A, n / 16, n % 16)) begin
          errs++;
          if (n < 3) special_errs++;
        end
        n++;
      end
      if (done_s === 1'b1) begin ndone++; dcyc = c; end
      @(posedge clk); #1;
    end
    checks++; if (n != 48) begin failures++; $display("FAIL small_beat_count got %0d want 48", n); end
    checks++; if (special_errs != 0) begin failures++; $display("FAIL small_addr0_words got %0d bad want 0", special_errs); end
    checks++; if (errs != 0) begin failures++; $display("FAIL small_beats got %0d bad want 0", errs); end
    checks++; if (ndone != 1 || dcyc != 55) begin failures++; $display("FAIL small_done got %0d pulses at %0d want 1 at 55", ndone, dcyc); end
    checks++; if (busy_s !== 1'b0 || gen_key_s !== KEY_A) begin failures++; $display("FAIL small_end got busy=%b key=%h want 0 %h", busy_s, gen_key_s, KEY_A); end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_start_ignored();
    test_back_to_back_stall();
    test_abort();
    test_reset_midstall();
    test_small_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbl_write_seq.md
Name: wbl_write_seq

Overview:
- Sequential consumer of the combinational WBL key generator: steps generator address 0..NUM_ADDR-1 over a latched AES-128 key.
- Per address: waits a settle window, captures the 16 64-bit WBL words, streams them one per handshake to the DRAM-CIM array write port.
- Sits between the key-load controller (start/key) and the array write driver; turns the wide combinational generator into a multi-cycle, back-pressured write stream.

Parameters:
- NUM_ADDR, 64, addresses swept per run (1..64); generator address width fixed at 6.
- SETTLE_CYCLES, 2, cycles gen_addr is held before capture, ≥1; multicycle budget for the generator path.
- NUM_WORDS, 16, WBL words per address; fixed, documents the beat count.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- key_in  in  128  AES-128 key, latched when start is accepted.
- gen_key  out  128  latched key to generator Kin.
- gen_addr  out  6  generator addr.
- gen_wbl  in  1024  generator outputs packed {WBL1,...,WBL16}; WBL1 = [1023:960].
- wr_valid  out  1  write beat valid.
- wr_ready  in  1  array write driver ready.
- wr_addr  out  6  array row of current beat (= address being written).
- wr_word  out  4  beat index 0..15; index k carries WBL(k+1).
- wr_data  out  64  beat data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal sweep completion.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; gen_key=0, gen_addr=0, wr_valid=0, wr_addr=0, wr_word=0, wr_data=0, busy=0, done=0; capture buffer cleared. Reset overrides everything, including mid-sweep and mid-stall.
- IDLE:
  - start=1 → latch key_in into gen_key, gen_addr=0, settle counter=0, go to SETTLE.
  - key_in changes after acceptance have no effect.
  - start while busy is ignored, not queued.
- SETTLE: hold gen_addr; counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to CAPTURE.
- CAPTURE: exactly one cycle; register all 1024 bits of gen_wbl into the buffer; beat index=0; go to WRITE.
- WRITE:
  - wr_valid=1; wr_data=buffer word[beat]; wr_word=beat; wr_addr=gen_addr.
  - Outputs stay stable while wr_ready=0; unbounded stall allowed.
  - On wr_valid & wr_ready with beat<15: beat+1.
  - On beat==15 with gen_addr<NUM_ADDR-1: gen_addr+1, counter=0, go to SETTLE.
  - On beat==15 with gen_addr==NUM_ADDR-1: go to DONE.
- DONE: done=1 and busy=1 for one cycle; then IDLE. gen_key is retained.
- wr_valid is 0 in all states except WRITE; wr_data is a don't-care then but must hold its last value (no X).
- abort=1 in any non-IDLE state: next state IDLE, wr_valid=0, no done pulse. abort has priority over a coinciding handshake, and that beat is counted as not taken. abort in IDLE has no effect.
- Throughput with wr_ready tied high: SETTLE_CYCLES+1+16 cycles per address. Start edge E0 → first SETTLE cycle is cycle 1 → done high in cycle NUM_ADDR·(SETTLE_CYCLES+17)+1. Defaults give cycle 1217.
- Wrap-around:
  - gen_addr never exceeds NUM_ADDR-1.
  - Beat index wraps only via address advance.
  - Counters sized so NUM_ADDR=64 terminates without overflow.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, wr_ready=1, defaults → 1024 beats in order (addr 0..63, word 0..15), each wr_data equal to the reference generator WBL(word+1) for that addr. done pulses in cycle 1217 only; busy falls the cycle after.
- Same key, wr_ready randomly low ~50% incl. 20-cycle stall on addr 32 word 0 → identical beat sequence and data; outputs constant through every stall; done after the last handshake.
- start pulsed again at cycle 100 with different key_in → ignored; all data still derived from the first key; single done pulse.
- abort at the handshake of addr 5 word 7 → no further beats, no done, busy=0 next cycle. New start then restarts from addr 0 word 0.
- rst_n=0 during WRITE stall at addr 10 → all outputs at reset values next cycle. start after release → full sweep from addr 0.
- NUM_ADDR=3, SETTLE_CYCLES=1 → 48 beats for addrs 0..2; addr 0 words 0..2 match generator special rows. done in cycle 3·18+1=55.
